// File: rtl/fb_pkg.sv
// Shared geometry, op encodings, state encoding and pixel-op helper for the
// 1-bpp frame-buffer plot controller. FB_FILL_EN adds the FILL state.
package fb_pkg;

    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned H_TOTAL  = 1056;
    localparam int unsigned WORDS    = 24000;

    localparam logic [1:0] OP_SET = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_TGL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MOD  = 3'd2,
`ifdef FB_FILL_EN
        WR   = 3'd3,
        FILL = 3'd4
`else
        WR   = 3'd3
`endif
    } state_e;

    // Apply a set/clear/toggle to one bit of a frame-buffer word.
    function automatic logic [15:0] apply_op(input logic [15:0] w,
                                             input logic [3:0]  b,
                                             input logic [1:0]  op);
        logic [15:0] m;
        m = 16'h0001 << b;
        case (op)
            OP_SET:  return w | m;
            OP_CLR:  return w & ~m;
            OP_TGL:  return w ^ m;
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Pixel (x, y) to frame-buffer word address and bit index, combinational.
module fb_addr_calc
    import fb_pkg::*;
(
    input  logic [10:0] x,
    input  logic [10:0] y,
    output logic [15:0] word,
    output logic [3:0]  bit_idx
);

    logic [18:0] idx;

    // Linear pixel index at 19 bits; word is idx>>4 widened to 16 bits.
    always_comb begin
        idx     = 19'(x) + 19'(y) * 19'(H_ACTIVE);
        word    = {1'b0, idx[18:4]};
        bit_idx = idx[3:0];
    end

endmodule

// File: rtl/fb_rmw_ctrl.sv
// Pixel-plot read-modify-write controller for the 800x480 1-bpp frame buffer.
// Borrows the vga_ram read port only in blanking. Define FB_FILL_EN to add
// the fill_start/fill_pattern ports and the whole-buffer FILL state.
module fb_rmw_ctrl
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] vga_h,
    input  logic [10:0] vga_v,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [10:0] req_x,
    input  logic [10:0] req_y,
    input  logic [1:0]  req_op,
    output logic [15:0] ram_read_address,
    input  logic [15:0] ram_q,
    output logic [15:0] ram_write_address,
    output logic [15:0] ram_data,
    output logic        ram_we,
    output logic        busy,
`ifdef FB_FILL_EN
    input  logic        fill_start,
    input  logic [15:0] fill_pattern,
`endif
    output logic        err_oob
);

    state_e      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] ram_data_q, ram_data_d;
    logic [15:0] ram_write_address_q, ram_write_address_d;
    logic        err_oob_q, err_oob_d;
    logic        fwd_valid_q, fwd_valid_d;

    logic [15:0] req_word, disp_word;
    logic [3:0]  req_bit, disp_bit_unused;
    logic        vblank, hblank, win, req_oob, handshake, fill_go;
    logic [15:0] mod_base;

    fb_addr_calc u_req_addr (
        .x       (req_x),
        .y       (req_y),
        .word    (req_word),
        .bit_idx (req_bit)
    );

    fb_addr_calc u_disp_addr (
        .x       (vga_h),
        .y       (vga_v),
        .word    (disp_word),
        .bit_idx (disp_bit_unused)
    );

    // Start window and request handshake; fill_start outranks a plot request.
    always_comb begin
`ifdef FB_FILL_EN
        fill_go = (state_q == IDLE) && fill_start;
`else
        fill_go = 1'b0;
`endif
        vblank    = vga_v >= 11'(V_ACTIVE);
        hblank    = vga_h >= 11'(H_ACTIVE);
        win       = (hblank || vblank) && (vblank || (vga_h < 11'(H_TOTAL - 2)));
        req_oob   = (req_x >= 11'(H_ACTIVE)) || (req_y >= 11'(V_ACTIVE));
        req_ready = (state_q == IDLE) && win && !fill_go;
        handshake = req_valid && req_ready;
    end

    // Read data for the modify step; the last written word is forwarded on a hit.
    always_comb begin
        mod_base = (fwd_valid_q && (word_q == ram_write_address_q)) ? ram_data_q : ram_q;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d             = state_q;
        word_d              = word_q;
        bit_d               = bit_q;
        op_d                = op_q;
        ram_data_d          = ram_data_q;
        ram_write_address_d = ram_write_address_q;
        err_oob_d           = 1'b0;
        fwd_valid_d         = fwd_valid_q;
        case (state_q)
            IDLE: begin
`ifdef FB_FILL_EN
                if (fill_go) begin
                    state_d             = FILL;
                    ram_write_address_d = '0;
                    ram_data_d          = fill_pattern;
                end else
`endif
                if (handshake) begin
                    if (req_oob) begin
                        err_oob_d = 1'b1;
                    end else if (req_op != OP_RSV) begin
                        word_d  = req_word;
                        bit_d   = req_bit;
                        op_d    = req_op;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = MOD;
            end
            MOD: begin
                ram_data_d          = apply_op(mod_base, bit_q, op_q);
                ram_write_address_d = word_q;
                state_d             = WR;
            end
            WR: begin
                fwd_valid_d = 1'b1;
                state_d     = IDLE;
            end
`ifdef FB_FILL_EN
            FILL: begin
                // The write-address register doubles as the fill counter, so
                // the last filled word is also a valid forwarding source.
                fwd_valid_d = 1'b1;
                if (ram_write_address_q == 16'(WORDS - 1)) begin
                    state_d = IDLE;
                end else begin
                    ram_write_address_d = ram_write_address_q + 16'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= IDLE;
            word_q              <= '0;
            bit_q               <= '0;
            op_q                <= '0;
            ram_data_q          <= '0;
            ram_write_address_q <= '0;
            err_oob_q           <= 1'b0;
            fwd_valid_q         <= 1'b0;
        end else begin
            state_q             <= state_d;
            word_q              <= word_d;
            bit_q               <= bit_d;
            op_q                <= op_d;
            ram_data_q          <= ram_data_d;
            ram_write_address_q <= ram_write_address_d;
            err_oob_q           <= err_oob_d;
            fwd_valid_q         <= fwd_valid_d;
        end
    end

    // Output decode.
    always_comb begin
        ram_read_address  = (state_q == RD) ? word_q : disp_word;
        ram_write_address = ram_write_address_q;
        ram_data          = ram_data_q;
        err_oob           = err_oob_q;
        busy              = state_q != IDLE;
`ifdef FB_FILL_EN
        ram_we            = (state_q == WR) || (state_q == FILL);
`else
        ram_we            = state_q == WR;
`endif
    end

endmodule

// File: tb/tb_fb_rmw_ctrl.sv
// Directed bench for fb_rmw_ctrl with a behavioural vga_ram model.
// Fill checks are compiled in when FB_FILL_EN is defined.
module tb_fb_rmw_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] vga_h, vga_v;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_x, req_y;
    logic [1:0]  req_op;
    logic [15:0] ram_read_address;
    logic [15:0] ram_q;
    logic [15:0] ram_write_address;
    logic [15:0] ram_data;
    logic        ram_we;
    logic        busy;
    logic        err_oob;
`ifdef FB_FILL_EN
    logic        fill_start;
    logic [15:0] fill_pattern;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned we_count = 0;
    logic [15:0] mem [0:65535];

    fb_rmw_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .vga_h             (vga_h),
        .vga_v             (vga_v),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_x             (req_x),
        .req_y             (req_y),
        .req_op            (req_op),
        .ram_read_address  (ram_read_address),
        .ram_q             (ram_q),
        .ram_write_address (ram_write_address),
        .ram_data          (ram_data),
        .ram_we            (ram_we),
        .busy              (busy),
`ifdef FB_FILL_EN
        .fill_start        (fill_start),
        .fill_pattern      (fill_pattern),
`endif
        .err_oob           (err_oob)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
    end

    // vga_ram model: registered read, write on the clock edge.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_write_address] <= ram_data;
            we_count <= we_count + 1;
        end
        ram_q <= mem[ram_read_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns one cycle after the handshake.
    task automatic do_req(input logic [10:0] x, input logic [10:0] y,
                          input logic [1:0] op, input string tag);
        req_x = x; req_y = y; req_op = op; req_valid = 1'b1;
        #1;
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    // Full RMW: checks the write cycle and returns in the following IDLE cycle.
    task automatic run_op(input logic [10:0] x, input logic [10:0] y,
                          input logic [1:0] op, input logic [15:0] addr,
                          input logic [15:0] data, input string tag);
        do_req(x, y, op, tag);
        step();
        step();
        check({tag, " we"},    32'(ram_we), 32'd1);
        check({tag, " waddr"}, 32'(ram_write_address), 32'(addr));
        check({tag, " wdata"}, 32'(ram_data), 32'(data));
        step();
    endtask

    int unsigned we_base;

    initial begin
        reset = 1'b1; vga_h = 11'd5; vga_v = 11'd1;
        req_valid = 1'b0; req_x = '0; req_y = '0; req_op = 2'b00;
`ifdef FB_FILL_EN
        fill_start = 1'b0; fill_pattern = 16'hA5A5;
`endif
        #12;
        check("rst busy",  32'(busy), 32'd0);
        check("rst we",    32'(ram_we), 32'd0);
        check("rst waddr", 32'(ram_write_address), 32'd0);
        check("rst wdata", 32'(ram_data), 32'd0);
        check("rst err",   32'(err_oob), 32'd0);
        check("rst raddr", 32'(ram_read_address), 32'd50);
        step();
        reset = 1'b0;
        vga_h = 11'd100; vga_v = 11'd490;
        step();

        // Out-of-range requests in vertical blank.
        we_base = we_count;
        do_req(11'd800, 11'd0, 2'b00, "oob800");
        check("oob800 err",  32'(err_oob), 32'd1);
        check("oob800 busy", 32'(busy), 32'd0);
        step();
        check("oob800 err clr", 32'(err_oob), 32'd0);
        do_req(11'd805, 11'd0, 2'b00, "oob805");
        check("oob805 err", 32'(err_oob), 32'd1);
        step();
        do_req(11'd5, 11'd480, 2'b00, "oobY");
        check("oobY err", 32'(err_oob), 32'd1);
        step();
        check("oob no we", we_count - we_base, 32'd0);

        // Set x=5,y=1: word 50 bit 5, with per-cycle read-port checks.
        do_req(11'd5, 11'd1, 2'b00, "set5");
        check("RD raddr",   32'(ram_read_address), 32'd50);
        check("RD we",      32'(ram_we), 32'd0);
        check("RD busy",    32'(busy), 32'd1);
        step();
        check("MOD raddr",  32'(ram_read_address), 32'd24506);
        check("MOD we",     32'(ram_we), 32'd0);
        step();
        check("WR we",      32'(ram_we), 32'd1);
        check("WR waddr",   32'(ram_write_address), 32'd50);
        check("WR wdata",   32'(ram_data), 32'h0020);
        check("WR raddr",   32'(ram_read_address), 32'd24506);
        step();
        check("set5 idle",  32'(busy), 32'd0);
        check("set5 mem",   32'(mem[50]), 32'h0020);

        // Clear, then two back-to-back toggles of the same pixel.
        run_op(11'd5, 11'd1, 2'b01, 16'd50, 16'h0000, "clr5");
        run_op(11'd5, 11'd1, 2'b10, 16'd50, 16'h0020, "tgl5a");
        run_op(11'd5, 11'd1, 2'b10, 16'd50, 16'h0000, "tgl5b");
        check("tgl mem", 32'(mem[50]), 32'h0000);
        run_op(11'd15, 11'd1, 2'b00, 16'd50, 16'h8000, "set15");
        run_op(11'd799, 11'd479, 2'b00, 16'd23999, 16'h8000, "setlast");

        // Reserved op: accepted, no access, no error.
        we_base = we_count;
        do_req(11'd5, 11'd1, 2'b11, "rsv");
        check("rsv busy", 32'(busy), 32'd0);
        check("rsv err",  32'(err_oob), 32'd0);
        step();
        check("rsv no we", we_count - we_base, 32'd0);

        // Horizontal sweep on a visible line with a request held.
        vga_v = 11'd100;
        req_x = 11'd900; req_y = 11'd0; req_op = 2'b00; req_valid = 1'b1;
        for (int h = 790; h <= 1055; h++) begin
            vga_h = 11'(h);
            #1;
            check($sformatf("sweep ready h=%0d", h), 32'(req_ready),
                  32'((h >= 800) && (h < 1054)));
            check($sformatf("sweep raddr h=%0d", h), 32'(ram_read_address),
                  32'((h + 80000) / 16));
            step();
        end
        req_valid = 1'b0;
        step();
        vga_v = 11'd490; vga_h = 11'd1055;
        #1;
        check("vblank ready h=1055", 32'(req_ready), 32'd1);
        vga_v = 11'd479; vga_h = 11'd1054;
        #1;
        check("hblank ready h=1054", 32'(req_ready), 32'd0);
        vga_v = 11'd490; vga_h = 11'd100;
        step();

        // Reset while in MOD aborts without a write.
        we_base = we_count;
        do_req(11'd20, 11'd2, 2'b00, "abort");
        step();
        check("abort in MOD", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort busy",  32'(busy), 32'd0);
        check("abort we",    32'(ram_we), 32'd0);
        check("abort waddr", 32'(ram_write_address), 32'd0);
        check("abort wdata", 32'(ram_data), 32'd0);
        check("abort err",   32'(err_oob), 32'd0);
        check("abort raddr", 32'(ram_read_address), 32'd24506);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check("abort no we",  we_count - we_base, 32'd0);
        check("abort mem101", 32'(mem[101]), 32'd0);

`ifdef FB_FILL_EN
        begin
            int unsigned n = 0;
            int unsigned bad = 0;
            int unsigned cyc = 0;
            req_x = 11'd1; req_y = 11'd1; req_op = 2'b00; req_valid = 1'b1;
            fill_start = 1'b1;
            #1;
            check("fill prio ready", 32'(req_ready), 32'd0);
            step();
            fill_start = 1'b0;
            while (busy && cyc < 24100) begin
                if (req_ready) bad++;
                if (ram_we) begin
                    if (ram_write_address != 16'(n) || ram_data != 16'hA5A5) bad++;
                    n++;
                end
                cyc++;
                step();
            end
            check("fill timeout", 32'(busy), 32'd0);
            check("fill count",   n, 32'd24000);
            check("fill bad",     bad, 32'd0);
            check("fill mem0",    32'(mem[0]), 32'hA5A5);
            check("fill post ready", 32'(req_ready), 32'd1);
            step();
            req_valid = 1'b0;
            step();
            step();
            check("post fill we",    32'(ram_we), 32'd1);
            check("post fill waddr", 32'(ram_write_address), 32'd50);
            check("post fill wdata", 32'(ram_data), 32'hA5A7);
            step();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
